// File: rtl/wb_select_stage.sv
// Writeback stage: selects a result source, extracts/extends memory loads and
// registers the result behind a valid/ready handshake feeding the register file.
module wb_select_stage #(
   parameter int DATA_W  = 32,
   parameter int NUM_SRC = 4,
   parameter int SEL_W   = 3,
   parameter int MEM_IDX = 1,
   parameter int ADDR_W  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_SRC*DATA_W-1:0] in_src,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic [1:0]                in_mem_size,
   input  logic                      in_mem_sign,
   input  logic [1:0]                in_byte_off,
   input  logic [ADDR_W-1:0]         in_rd,
   input  logic                      in_reg_write,
   input  logic                      wb_stall,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic                      fwd_valid,
   output logic [ADDR_W-1:0]         fwd_addr,
   output logic [DATA_W-1:0]         fwd_data,
   output logic                      sel_err
);

   localparam logic [SEL_W:0]   NumSrcC = (SEL_W+1)'(NUM_SRC);
   localparam logic [SEL_W-1:0] MemIdxC = SEL_W'(MEM_IDX);

   logic [DATA_W-1:0] srcWord;
   logic [7:0]        byteVal;
   logic [15:0]       halfVal;
   logic [DATA_W-1:0] loadData;
   logic              misalign;
   logic              selLegal;
   logic              isMem;
   logic [DATA_W-1:0] capData;
   logic              capErr;
   logic              capWrite;
   logic              capture;

   logic              outValid_q,  outValid_d;
   logic [ADDR_W-1:0] wrAddr_q,    wrAddr_d;
   logic [DATA_W-1:0] wrData_q,    wrData_d;
   logic              regWrite_q,  regWrite_d;
   logic              selErr_q,    selErr_d;

   always_comb begin
      srcWord = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (in_sel == SEL_W'(k)) srcWord = in_src[k*DATA_W +: DATA_W];
      end

      unique case (in_byte_off)
         2'b00:   byteVal = srcWord[7:0];
         2'b01:   byteVal = srcWord[15:8];
         2'b10:   byteVal = srcWord[23:16];
         default: byteVal = srcWord[31:24];
      endcase
      halfVal = in_byte_off[1] ? srcWord[31:16] : srcWord[15:0];

      // Reserved size 11 loads the whole word and is never flagged misaligned.
      misalign = 1'b0;
      unique case (in_mem_size)
         2'b00: loadData = {{(DATA_W-8){in_mem_sign & byteVal[7]}}, byteVal};
         2'b01: begin
            loadData = {{(DATA_W-16){in_mem_sign & halfVal[15]}}, halfVal};
            misalign = in_byte_off[0];
         end
         2'b10: begin
            loadData = srcWord;
            misalign = (in_byte_off != 2'b00);
         end
         default: loadData = srcWord;
      endcase

      selLegal = ({1'b0, in_sel} < NumSrcC);
      isMem    = (in_sel == MemIdxC);
      capErr   = !selLegal | (isMem & misalign);
      capData  = !selLegal ? '0 : (isMem ? loadData : srcWord);
      capWrite = in_reg_write & !capErr & (in_rd != '0);
   end

   assign in_ready = !outValid_q | !wb_stall;
   assign capture  = in_valid & in_ready;

   always_comb begin
      outValid_d = outValid_q;
      wrAddr_d   = wrAddr_q;
      wrData_d   = wrData_q;
      regWrite_d = regWrite_q;
      selErr_d   = selErr_q | (capture & capErr);
      if (capture) begin
         outValid_d = 1'b1;
         wrAddr_d   = in_rd;
         wrData_d   = capData;
         regWrite_d = capWrite;
      end else if (!wb_stall) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
         regWrite_q <= 1'b0;
         selErr_q   <= 1'b0;
      end else begin
         outValid_q <= outValid_d;
         wrAddr_q   <= wrAddr_d;
         wrData_q   <= wrData_d;
         regWrite_q <= regWrite_d;
         selErr_q   <= selErr_d;
      end
   end

   assign wr_en     = outValid_q & regWrite_q & !wb_stall;
   assign wr_addr   = wrAddr_q;
   assign wr_data   = wrData_q;
   assign fwd_valid = outValid_q & regWrite_q;
   assign fwd_addr  = wrAddr_q;
   assign fwd_data  = wrData_q;
   assign sel_err   = selErr_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Testbench for wb_select_stage: directed scenarios plus a randomized run
// against a behavioural model of the writeback rules.
module tb_wb_select_stage;

   localparam int DW = 32;
   localparam int NS = 3;
   localparam int SW = 3;
   localparam int MI = 1;
   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [NS*DW-1:0] in_src;
   logic [SW-1:0]  in_sel;
   logic [1:0]     in_mem_size;
   logic           in_mem_sign;
   logic [1:0]     in_byte_off;
   logic [AW-1:0]  in_rd;
   logic           in_reg_write;
   logic           wb_stall;
   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic [DW-1:0]  wr_data;
   logic           fwd_valid;
   logic [AW-1:0]  fwd_addr;
   logic [DW-1:0]  fwd_data;
   logic           sel_err;

   int checks = 0;
   int passes = 0;

   logic          mValid, mWe, mErr;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mData;

   wb_select_stage #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .MEM_IDX(MI), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
      .in_sel(in_sel), .in_mem_size(in_mem_size), .in_mem_sign(in_mem_sign),
      .in_byte_off(in_byte_off), .in_rd(in_rd), .in_reg_write(in_reg_write),
      .wb_stall(wb_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic setIdle();
      in_valid = 1'b0; wb_stall = 1'b0; in_sel = '0; in_src = '0; in_mem_size = 2'b10;
      in_mem_sign = 1'b0; in_byte_off = 2'b00; in_rd = '0; in_reg_write = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      setIdle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mValid = 1'b0; mWe = 1'b0; mErr = 1'b0; mAddr = '0; mData = '0;
   endtask

   // Expected result of a capture, computed from the selection and load rules.
   function automatic void refCompute(input logic [SW-1:0] sel, input logic [NS*DW-1:0] src,
                                      input logic [1:0] size, input logic sign,
                                      input logic [1:0] off, output logic [DW-1:0] d,
                                      output logic e);
      logic [DW-1:0] w;
      e = 1'b0;
      d = '0;
      if (int'(sel) >= NS) begin
         e = 1'b1;
      end else begin
         w = src[int'(sel)*DW +: DW];
         if (int'(sel) != MI) d = w;
         else begin
            case (size)
               2'd0: begin
                  d = (w >> (8 * int'(off))) & 32'hFF;
                  if (sign && d >= 128) d = d - 256;
               end
               2'd1: begin
                  d = (w >> (16 * int'(off[1]))) & 32'hFFFF;
                  if (sign && d >= 32768) d = d - 65536;
                  e = off[0];
               end
               2'd2: begin
                  d = w;
                  e = (off != 2'b00);
               end
               default: d = w;
            endcase
         end
      end
   endfunction

   task automatic test_reset();
      doReset();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en); else passes++;
      checks++; if (fwd_valid !== 1'b0) $display("[TB] FAIL reset_fwd_valid: got %b expected 0", fwd_valid); else passes++;
      checks++; if (sel_err !== 1'b0) $display("[TB] FAIL reset_sel_err: got %b expected 0", sel_err); else passes++;
      checks++; if (wr_data !== 32'h0) $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); else passes++;
      checks++; if (wr_addr !== 5'd0) $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
      @(negedge clk);
   endtask

   task automatic test_alu();
      doReset();
      in_valid = 1'b1; in_sel = 3'd0; in_src = {32'hAAAA_0002, 32'hBBBB_0001, 32'h1234_5678};
      in_rd = 5'd5; in_reg_write = 1'b1;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL alu_wr_en: got %b expected 1", wr_en); else passes++;
      checks++; if (wr_addr !== 5'd5) $display("[TB] FAIL alu_wr_addr: got %0d expected 5", wr_addr); else passes++;
      checks++; if (wr_data !== 32'h1234_5678) $display("[TB] FAIL alu_wr_data: got %h expected 12345678", wr_data); else passes++;
      checks++; if (fwd_valid !== 1'b1) $display("[TB] FAIL alu_fwd_valid: got %b expected 1", fwd_valid); else passes++;
      cycle();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL alu_single_write: got %b expected 0", wr_en); else passes++;
   endtask

   task automatic test_loads();
      doReset();
      in_valid = 1'b1; in_sel = 3'd1; in_src = {32'h0, 32'h80FF_7F01, 32'h0};
      in_mem_size = 2'b00; in_byte_off = 2'd3; in_mem_sign = 1'b1; in_rd = 5'd7; in_reg_write = 1'b1;
      cycle();
      in_mem_sign = 1'b0;
      #1;
      checks++; if (wr_data !== 32'hFFFF_FF80) $display("[TB] FAIL sbyte_data: got %h expected ffffff80", wr_data); else passes++;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL sbyte_wr_en: got %b expected 1", wr_en); else passes++;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_data !== 32'h0000_0080) $display("[TB] FAIL ubyte_data: got %h expected 00000080", wr_data); else passes++;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL ubyte_wr_en: got %b expected 1", wr_en); else passes++;
      cycle();
      in_valid = 1'b1; in_sel = 3'd1; in_src = {32'h0, 32'h8001_0000, 32'h0};
      in_mem_size = 2'b01; in_byte_off = 2'd2; in_mem_sign = 1'b1; in_rd = 5'd9; in_reg_write = 1'b1;
      cycle();
      in_byte_off = 2'd1;
      #1;
      checks++; if (wr_data !== 32'hFFFF_8001) $display("[TB] FAIL shalf_data: got %h expected ffff8001", wr_data); else passes++;
      checks++; if (sel_err !== 1'b0) $display("[TB] FAIL shalf_no_err: got %b expected 0", sel_err); else passes++;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL mis_half_wr_en: got %b expected 0", wr_en); else passes++;
      checks++; if (sel_err !== 1'b1) $display("[TB] FAIL mis_half_err: got %b expected 1", sel_err); else passes++;
      cycle();
      cycle();
      #1;
      checks++; if (sel_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", sel_err); else passes++;
   endtask

   task automatic test_illegal_sel();
      doReset();
      in_valid = 1'b1; in_sel = 3'd3; in_src = '1; in_rd = 5'd9; in_reg_write = 1'b1;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_data !== 32'h0) $display("[TB] FAIL illegal_data: got %h expected 0", wr_data); else passes++;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL illegal_wr_en: got %b expected 0", wr_en); else passes++;
      checks++; if (sel_err !== 1'b1) $display("[TB] FAIL illegal_err: got %b expected 1", sel_err); else passes++;
      doReset();
      in_valid = 1'b1; in_sel = 3'd0; in_src = {32'h0, 32'h0, 32'h55}; in_rd = 5'd0; in_reg_write = 1'b1;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL rd0_wr_en: got %b expected 0", wr_en); else passes++;
      checks++; if (fwd_valid !== 1'b0) $display("[TB] FAIL rd0_fwd: got %b expected 0", fwd_valid); else passes++;
      checks++; if (sel_err !== 1'b0) $display("[TB] FAIL rd0_err: got %b expected 0", sel_err); else passes++;
   endtask

   task automatic test_back_to_back();
      doReset();
      in_valid = 1'b1; in_sel = 3'd0; in_src = {64'h0, 32'hA0A0_A0A0}; in_rd = 5'd3; in_reg_write = 1'b1;
      cycle();
      in_src = {64'h0, 32'hB0B0_B0B0}; in_rd = 5'd4; wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); else passes++;
         checks++; if (wr_en !== 1'b0) $display("[TB] FAIL stall_wr_en[%0d]: got %b expected 0", i, wr_en); else passes++;
         checks++; if (fwd_valid !== 1'b1) $display("[TB] FAIL stall_fwd[%0d]: got %b expected 1", i, fwd_valid); else passes++;
         checks++; if (wr_data !== 32'hA0A0_A0A0) $display("[TB] FAIL stall_data[%0d]: got %h expected a0a0a0a0", i, wr_data); else passes++;
         cycle();
      end
      wb_stall = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL a_wr_en: got %b expected 1", wr_en); else passes++;
      checks++; if (wr_data !== 32'hA0A0_A0A0) $display("[TB] FAIL a_data: got %h expected a0a0a0a0", wr_data); else passes++;
      checks++; if (wr_addr !== 5'd3) $display("[TB] FAIL a_addr: got %0d expected 3", wr_addr); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL a_ready: got %b expected 1", in_ready); else passes++;
      cycle();
      in_valid = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL b_wr_en: got %b expected 1", wr_en); else passes++;
      checks++; if (wr_data !== 32'hB0B0_B0B0) $display("[TB] FAIL b_data: got %h expected b0b0b0b0", wr_data); else passes++;
      checks++; if (wr_addr !== 5'd4) $display("[TB] FAIL b_addr: got %0d expected 4", wr_addr); else passes++;
      cycle();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL b2b_no_dup: got %b expected 0", wr_en); else passes++;
   endtask

   task automatic test_reset_mid_stall();
      doReset();
      in_valid = 1'b1; in_sel = 3'd3; in_rd = 5'd2; in_reg_write = 1'b1;
      cycle();
      in_sel = 3'd0; in_src = {64'h0, 32'h6666_6666}; in_rd = 5'd6;
      cycle();
      in_valid = 1'b0; wb_stall = 1'b1;
      cycle();
      #1;
      checks++; if (fwd_valid !== 1'b1) $display("[TB] FAIL pre_rst_fwd: got %b expected 1", fwd_valid); else passes++;
      checks++; if (sel_err !== 1'b1) $display("[TB] FAIL pre_rst_err: got %b expected 1", sel_err); else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL rst_wr_en: got %b expected 0", wr_en); else passes++;
      checks++; if (fwd_valid !== 1'b0) $display("[TB] FAIL rst_fwd: got %b expected 0", fwd_valid); else passes++;
      checks++; if (sel_err !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", sel_err); else passes++;
      @(negedge clk);
      rst_n = 1'b1; wb_stall = 1'b0;
      in_valid = 1'b1; in_sel = 3'd2; in_src = {32'hC0C0_C0C0, 64'h0}; in_rd = 5'd8; in_reg_write = 1'b1;
      cycle();
      setIdle();
      #1;
      checks++; if (wr_en !== 1'b1) $display("[TB] FAIL post_rst_wr_en: got %b expected 1", wr_en); else passes++;
      checks++; if (wr_addr !== 5'd8) $display("[TB] FAIL post_rst_addr: got %0d expected 8", wr_addr); else passes++;
      checks++; if (wr_data !== 32'hC0C0_C0C0) $display("[TB] FAIL post_rst_data: got %h expected c0c0c0c0", wr_data); else passes++;
      cycle();
      #1;
      checks++; if (wr_en !== 1'b0) $display("[TB] FAIL post_rst_no_dup: got %b expected 0", wr_en); else passes++;
   endtask

   task automatic test_random();
      logic          eReady, eWe, eFwd, e;
      logic [DW-1:0] d;
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 0) doReset();
         in_valid     = ($urandom_range(0, 9) < 7);
         wb_stall     = ($urandom_range(0, 9) < 3);
         in_sel       = ($urandom_range(0, 9) < 4) ? 3'd1 : SW'($urandom_range(0, 4));
         in_src       = {$urandom, $urandom, $urandom};
         in_mem_size  = 2'($urandom_range(0, 3));
         in_mem_sign  = 1'($urandom_range(0, 1));
         in_byte_off  = 2'($urandom_range(0, 3));
         if (in_mem_size == 2'b11) in_byte_off = 2'b00;
         in_rd        = AW'($urandom_range(0, 31));
         in_reg_write = ($urandom_range(0, 4) != 0);
         #1;
         eReady = !mValid || !wb_stall;
         eWe    = mValid && mWe && !wb_stall;
         eFwd   = mValid && mWe;
         checks++; if (in_ready !== eReady) $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, eReady); else passes++;
         checks++; if (wr_en !== eWe) $display("[TB] FAIL rnd_wr_en[%0d]: got %b expected %b", i, wr_en, eWe); else passes++;
         checks++; if (fwd_valid !== eFwd) $display("[TB] FAIL rnd_fwd[%0d]: got %b expected %b", i, fwd_valid, eFwd); else passes++;
         checks++; if (sel_err !== mErr) $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", i, sel_err, mErr); else passes++;
         checks++; if (wr_addr !== mAddr) $display("[TB] FAIL rnd_addr[%0d]: got %0d expected %0d", i, wr_addr, mAddr); else passes++;
         checks++; if (wr_data !== mData) $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", i, wr_data, mData); else passes++;
         checks++; if (fwd_addr !== mAddr) $display("[TB] FAIL rnd_faddr[%0d]: got %0d expected %0d", i, fwd_addr, mAddr); else passes++;
         checks++; if (fwd_data !== mData) $display("[TB] FAIL rnd_fdata[%0d]: got %h expected %h", i, fwd_data, mData); else passes++;
         if (in_valid && eReady) begin
            refCompute(in_sel, in_src, in_mem_size, in_mem_sign, in_byte_off, d, e);
            mValid = 1'b1;
            mAddr  = in_rd;
            mData  = d;
            mWe    = in_reg_write && !e && (in_rd != 0);
            mErr   = mErr || e;
         end else if (!wb_stall) begin
            mValid = 1'b0;
         end
         cycle();
      end
   endtask

   initial begin
      rst_n = 1'b1;
      setIdle();
      test_reset();
      test_alu();
      test_loads();
      test_illegal_sel();
      test_back_to_back();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
